filter_out_fifo: RTL and testbench

//  Output buffer directly downstream of filter_unit: captures each result sample (ext_out/extvalid_out
//  of the filter) and presents it on a valid/ready stream to the consumer. Absorbs consumer stalls up
//  to DEPTH samples; flags overflow when the filter produces into a full buffer.

---
 rtl/myfilter_pkg.sv | 10 +
 rtl/filter_fifo_ram.sv | 29 ++
 rtl/filter_out_fifo_sva.sv | 41 ++++
 rtl/filter_out_fifo.sv | 88 ++++++++
 tb/tb_filter_out_fifo.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/myfilter_pkg.sv
// Shared constants and types for the filter datapath and its output buffer.
package myfilter_pkg;

  localparam int DATABITS       = 10;
  localparam int FIFO_DEPTH     = 16;
  localparam int FIFO_AF_MARGIN = 2;

  typedef logic [DATABITS-1:0] sample_t;

endpackage

// File: rtl/filter_fifo_ram.sv
// Storage array for the output FIFO: one write port, one asynchronous read port,
// every entry cleared on reset so the read port never shows X.
module filter_fifo_ram #(
  parameter int DATAW = 10,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [DATAW-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [DATAW-1:0] rdata
);

  logic [DATAW-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/filter_out_fifo_sva.sv
// Protocol and bookkeeping properties for filter_out_fifo, attached to every instance by bind.
module filter_out_fifo_sva #(
  parameter int DATAW = 10,
  parameter int DEPTH = 16
) (
  input logic                   clk,
  input logic                   rst,
  input logic                   flush_in,
  input logic                   ready_in,
  input logic                   pop,
  input logic                   valid_out,
  input logic [$clog2(DEPTH):0] level_out,
  input logic                   ovf_out,
  input logic [DATAW-1:0]       data_out
);

  localparam logic [$clog2(DEPTH):0] DEPTH_L = ($clog2(DEPTH) + 1)'(DEPTH);

  a_pop_needs_valid: assert property (@(posedge clk) disable iff (rst) pop |-> valid_out);
  a_level_bound:     assert property (@(posedge clk) disable iff (rst) level_out <= DEPTH_L);
  a_ovf_sticky:      assert property (@(posedge clk) disable iff (rst)
                                      ovf_out && !flush_in |=> ovf_out);
  a_head_stable:     assert property (@(posedge clk) disable iff (rst)
                                      valid_out && !ready_in && !flush_in |=> $stable(data_out));

endmodule

bind filter_out_fifo filter_out_fifo_sva #(
  .DATAW (DATAW),
  .DEPTH (DEPTH)
) u_sva (
  .clk       (clk),
  .rst       (rst),
  .flush_in  (flush_in),
  .ready_in  (ready_in),
  .pop       (pop),
  .valid_out (valid_out),
  .level_out (level_out),
  .ovf_out   (ovf_out),
  .data_out  (data_out)
);

// File: rtl/filter_out_fifo.sv
// First-word-fall-through buffer between filter_unit and its consumer.
// Stream out: a sample transfers on any edge where valid_out && ready_in; valid never waits on ready.
module filter_out_fifo
  import myfilter_pkg::*;
#(
  parameter int DATAW     = DATABITS,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int AF_MARGIN = FIFO_AF_MARGIN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_in,
  input  logic [DATAW-1:0]         ext_in,
  input  logic                     extvalid_in,
  output logic [DATAW-1:0]         data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   level_out,
  output logic                     almost_full_out,
  output logic                     ovf_out
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PTRW = AW + 1;
  localparam logic [PTRW-1:0] AF_LEVEL = PTRW'(DEPTH - AF_MARGIN);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("filter_out_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_MARGIN <= 0 || AF_MARGIN >= DEPTH) begin : g_bad_margin
    $error("filter_out_fifo: AF_MARGIN must satisfy 0 < AF_MARGIN < DEPTH");
  end

  logic [PTRW-1:0] wr_ptr, rd_ptr, level_next;
  logic            empty, full, pop, push, wr_en, ovf_set;

  // Extra pointer MSB separates full (MSBs differ) from empty (all bits equal).
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign valid_out = !empty;
  assign pop       = valid_out && ready_in;
  assign push      = extvalid_in && (!full || pop);
  assign ovf_set   = extvalid_in && full && !pop;
  assign wr_en     = push && !flush_in;

  always_comb begin
    level_next = level_out;
    if (push && !pop)      level_next = level_out + 1'b1;
    else if (pop && !push) level_next = level_out - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level_out       <= '0;
      almost_full_out <= 1'b0;
      ovf_out         <= 1'b0;
    end else if (flush_in) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level_out       <= '0;
      almost_full_out <= 1'b0;
      ovf_out         <= 1'b0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      level_out       <= level_next;
      almost_full_out <= (level_next >= AF_LEVEL);
      if (ovf_set) ovf_out <= 1'b1;
    end
  end

  filter_fifo_ram #(
    .DATAW (DATAW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (ext_in),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_filter_out_fifo.sv
// Directed bench for filter_out_fifo (DEPTH=16, AF_MARGIN=2, 10-bit samples).
module tb_filter_out_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush_in = 1'b0;
  logic [9:0] ext_in = '0;
  logic       extvalid_in = 1'b0;
  logic [9:0] data_out;
  logic       valid_out;
  logic       ready_in = 1'b0;
  logic [4:0] level_out;
  logic       almost_full_out;
  logic       ovf_out;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  logic       model_ovf = 1'b0;
  int         n_pop = 0;

  typedef struct {
    logic       ev;
    logic [9:0] ext;
    logic       rdy;
    logic       exp_valid;
    logic [9:0] exp_data;
    logic [4:0] exp_level;
    logic       exp_af;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[7];

  filter_out_fifo #(
    .DEPTH     (16),
    .AF_MARGIN (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_in        (flush_in),
    .ext_in          (ext_in),
    .extvalid_in     (extvalid_in),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .ready_in        (ready_in),
    .level_out       (level_out),
    .almost_full_out (almost_full_out),
    .ovf_out         (ovf_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, valid_out, 0);
    check({tag, "_data"},  data_out, 0);
    check({tag, "_level"}, level_out, 0);
    check({tag, "_af"},    almost_full_out, 0);
    check({tag, "_ovf"},   ovf_out, 0);
  endtask

  // One clock with a reference queue model: checks popped data, then level/flags after the edge.
  task automatic cycle(input logic ev, input logic [9:0] ext, input logic rdy, input logic fl);
    logic pop_m, push_m, drop_m;
    int   sz;
    extvalid_in = ev;
    ext_in      = ext;
    ready_in    = rdy;
    flush_in    = fl;
    sz     = exp_q.size();
    pop_m  = !fl && rdy && (sz > 0);
    push_m = !fl && ev && (sz < DEPTH || pop_m);
    drop_m = !fl && ev && !push_m;
    if (pop_m) check("pop_data", data_out, exp_q[0]);
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (pop_m) begin
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (push_m) exp_q.push_back(ext);
      if (drop_m) model_ovf = 1'b1;
    end
    extvalid_in = 1'b0;
    flush_in    = 1'b0;
    check("level", level_out, exp_q.size());
    check("valid", valid_out, exp_q.size() > 0);
    check("af",    almost_full_out, exp_q.size() >= DEPTH - 2);
    check("ovf",   ovf_out, model_ovf);
  endtask

  initial begin
    int p0;
    // latency / handshake table, starting from an empty buffer with ready_in varying
    vecs[0] = '{1'b1, 10'h0A5, 1'b1, 1'b1, 10'h0A5, 5'd1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 5'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 10'h123, 1'b0, 1'b1, 10'h123, 5'd1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 10'h045, 1'b0, 1'b1, 10'h123, 5'd2, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h045, 5'd1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 10'h3C3, 1'b1, 1'b1, 10'h3C3, 5'd1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 5'd0, 1'b0, 1'b0};

    // 1: reset held for 3 cycles, then idle
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_zero("rst_idle");
    end

    // 2: table-driven latency and handshake
    for (int i = 0; i < 7; i++) begin
      extvalid_in = vecs[i].ev;
      ext_in      = vecs[i].ext;
      ready_in    = vecs[i].rdy;
      @(posedge clk);
      #1;
      extvalid_in = 1'b0;
      check("tbl_valid", valid_out, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check("tbl_data", data_out, vecs[i].exp_data);
      check("tbl_level", level_out, vecs[i].exp_level);
      check("tbl_af",    almost_full_out, vecs[i].exp_af);
      check("tbl_ovf",   ovf_out, vecs[i].exp_ovf);
    end

    // 3: fill while stalled, overflow on the 17th, drain in order
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 10'(i), 1'b0, 1'b0);
      check("fill_level", level_out, i);
      check("fill_af", almost_full_out, i >= 14);
    end
    cycle(1'b1, 10'h3FF, 1'b0, 1'b0);
    check("ovf_set", ovf_out, 1);
    check("ovf_level", level_out, 16);
    for (int i = 1; i <= 16; i++) begin
      check("drain_order", data_out, i);
      cycle(1'b0, 10'h0, 1'b1, 1'b0);
    end
    check("drain_empty", valid_out, 0);
    check("ovf_held", ovf_out, 1);
    cycle(1'b0, 10'h0, 1'b0, 1'b1);
    check("flush_ovf_clr", ovf_out, 0);

    // 4: full buffer with simultaneous push and pop
    for (int i = 0; i < 16; i++) cycle(1'b1, 10'(10'h100 + i), 1'b0, 1'b0);
    check("full_head", data_out, 10'h100);
    cycle(1'b1, 10'h2AA, 1'b1, 1'b0);
    check("full_both_level", level_out, 16);
    check("full_both_ovf", ovf_out, 0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 10'h0, 1'b1, 1'b0);
    check("full_new_last", data_out, 10'h2AA);
    cycle(1'b0, 10'h0, 1'b1, 1'b0);
    check("full_drained", level_out, 0);

    // 5: random ready and gaps, ramp data, many pointer wraps
    p0 = n_pop;
    for (int s = 0; s < 100; s++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; (g < gap || exp_q.size() >= 14) && g < 200; g++)
        cycle(1'b0, 10'h0, 1'($urandom_range(0, 1)), 1'b0);
      cycle(1'b1, 10'(s + 1), 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) cycle(1'b0, 10'h0, 1'b1, 1'b0);
    check("wrap_count", n_pop - p0, 100);
    check("wrap_no_ovf", ovf_out, 0);

    // 6a: flush with a same-cycle strobe at level 9
    for (int i = 0; i < 9; i++) cycle(1'b1, 10'(10'h200 + i), 1'b0, 1'b0);
    check("pre_flush_level", level_out, 9);
    cycle(1'b1, 10'h155, 1'b1, 1'b1);
    check("flush_level", level_out, 0);
    check("flush_valid", valid_out, 0);
    check("flush_ovf", ovf_out, 0);
    cycle(1'b0, 10'h0, 1'b0, 1'b0);

    // 6b: asynchronous reset in the middle of a cycle
    for (int i = 0; i < 9; i++) cycle(1'b1, 10'(10'h300 + i), 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_ovf = 1'b0;
    cycle(1'b0, 10'h0, 1'b1, 1'b0);
    cycle(1'b1, 10'h0F0, 1'b0, 1'b0);
    check("post_rst_data", data_out, 10'h0F0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
